// File: rtl/fwd_pkg.sv
// Shared constants, FSM encoding and width helper for the forwarding/hazard unit.
package fwd_pkg;

  localparam int SEL_RF = 0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam int DEF_REG_W          = 4;
  localparam int DEF_NUM_SRC        = 3;
  localparam int DEF_NUM_FWD_STAGES = 2;
  localparam int DEF_LOAD_LAT       = 1;
  localparam int DEF_CNT_W          = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Priority forwarding selector for one EX-stage source against all forwarding stages.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_W          = DEF_REG_W,
  parameter int NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
  parameter int SEL_W          = clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                            fwd_en,
  input  logic [REG_W-1:0]                src,
  input  logic                            src_used,
  input  logic [NUM_FWD_STAGES*REG_W-1:0] stg_dest,
  input  logic [NUM_FWD_STAGES-1:0]       stg_wb_en,
  output logic [SEL_W-1:0]                sel
);

  logic [NUM_FWD_STAGES-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_FWD_STAGES; gi++) begin : g_stage
      assign hit[gi] = stg_wb_en[gi] && (stg_dest[gi*REG_W +: REG_W] == src);
    end
  endgenerate

  // Scan oldest to youngest so the lowest-index (youngest) producer is the last write.
  always_comb begin
    sel = SEL_W'(SEL_RF);
    if (fwd_en && src_used) begin
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        if (hit[k]) begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use / RAW hazard detection, bubble FSM and
// saturating stall-cycle counter for the in-order pipeline.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_W          = DEF_REG_W,
  parameter int NUM_SRC        = DEF_NUM_SRC,
  parameter int NUM_FWD_STAGES = DEF_NUM_FWD_STAGES,
  parameter int LOAD_LAT       = DEF_LOAD_LAT,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int SEL_W          = clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fwd_en,
  input  logic                            freeze,
  input  logic                            flush,
  input  logic [NUM_SRC*REG_W-1:0]        ex_src,
  input  logic [NUM_SRC-1:0]              ex_src_used,
  input  logic [NUM_FWD_STAGES*REG_W-1:0] stg_dest,
  input  logic [NUM_FWD_STAGES-1:0]       stg_wb_en,
  input  logic                            id_valid,
  input  logic [NUM_SRC*REG_W-1:0]        id_src,
  input  logic [NUM_SRC-1:0]              id_src_used,
  input  logic [REG_W-1:0]                ex_dest,
  input  logic                            ex_wb_en,
  input  logic                            ex_mem_rd,
  output logic [NUM_SRC*SEL_W-1:0]        sel,
  output logic                            stall,
  output logic [CNT_W-1:0]                stall_cycles
);

  localparam int LAT_W = (clog2(LOAD_LAT + 1) < 1) ? 1 : clog2(LOAD_LAT + 1);

  logic [NUM_SRC-1:0]                ex_hit;
  logic [NUM_SRC-1:0]                stg_hit;
  logic [NUM_SRC*NUM_FWD_STAGES-1:0] stg_eq;
  logic                              lu_hit;
  logic                              raw_hit;

  logic [0:0]       state_reg, state_next;
  logic [LAT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] stall_cycles_reg;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_src_sel #(
        .REG_W         (REG_W),
        .NUM_FWD_STAGES(NUM_FWD_STAGES),
        .SEL_W         (SEL_W)
      ) u_src_sel (
        .fwd_en   (fwd_en),
        .src      (ex_src[gi*REG_W +: REG_W]),
        .src_used (ex_src_used[gi]),
        .stg_dest (stg_dest),
        .stg_wb_en(stg_wb_en),
        .sel      (sel[gi*SEL_W +: SEL_W])
      );

      assign ex_hit[gi] = id_src_used[gi] && ex_wb_en &&
                          (id_src[gi*REG_W +: REG_W] == ex_dest);

      for (genvar gk = 0; gk < NUM_FWD_STAGES; gk++) begin : g_stg
        assign stg_eq[gi*NUM_FWD_STAGES + gk] = stg_wb_en[gk] &&
            (id_src[gi*REG_W +: REG_W] == stg_dest[gk*REG_W +: REG_W]);
      end

      assign stg_hit[gi] = id_src_used[gi] &&
                           (|stg_eq[gi*NUM_FWD_STAGES +: NUM_FWD_STAGES]);
    end
  endgenerate

  // Without forwarding, any in-flight producer of an ID source forces a stall.
  assign lu_hit  = fwd_en && id_valid && (|ex_hit) && ex_mem_rd;
  assign raw_hit = !fwd_en && id_valid && ((|ex_hit) || (|stg_hit));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (!freeze) begin
      if (state_reg == ST_HOLD) begin
        cnt_next = cnt_reg - LAT_W'(1);
        if (cnt_reg == LAT_W'(1)) begin
          state_next = ST_IDLE;
        end
      end else if (lu_hit && (LOAD_LAT > 1)) begin
        state_next = ST_HOLD;
        cnt_next   = LAT_W'(LOAD_LAT - 1);
      end
    end
  end

  // Reset and flush both force the stall low combinationally, not just at the next edge.
  always_comb begin
    stall = 1'b0;
    if (rst && !flush) begin
      stall = (state_reg == ST_HOLD) || lu_hit || raw_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (stall && !freeze && (stall_cycles_reg != {CNT_W{1'b1}})) begin
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule
